// File: rtl/fsm_pattern_sequencer.sv
// fsm_pattern_sequencer: steps two sequence-detector FSMs through a stored pattern and compares their z outputs.
// Optional HALT_ON_MISMATCH_EN ends the run on the CHECK that first records a mismatch.
module fsm_pattern_sequencer #(
    parameter int PAT_W = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             z_a,
    input  logic             z_b,
    output logic             w,
    output logic             fsm_reset,
    output logic             fsm_step,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] det_count,
    output logic             mismatch,
    output logic [CNT_W-1:0] first_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, DRIVE, STEP, CHECK, DONE} state_t;
    localparam logic [CNT_W-1:0] PAT_MAX = CNT_W'(PAT_W);
    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] eff_len_q, i_q, det_q, first_err_q;
    logic             w_q, fsm_reset_q, fsm_step_q, busy_q, done_q, mismatch_q;
    logic             last, set_mm, fin;
    always_comb begin
        last   = i_q == eff_len_q - 1'b1;
        set_mm = (z_a != z_b) && !mismatch_q;
`ifdef HALT_ON_MISMATCH_EN
        fin    = last || set_mm;
`else
        fin    = last;
`endif
    end
    // Outputs are set on the edge entering each state, so they are registered and glitch-free.
    // The pattern is shifted right per bit so the next bit is always pat_q[1].
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            eff_len_q   <= '0;
            i_q         <= '0;
            det_q       <= '0;
            first_err_q <= '0;
            w_q         <= 1'b0;
            fsm_reset_q <= 1'b0;
            fsm_step_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pat_q       <= pattern;
                    eff_len_q   <= (len > PAT_MAX) ? PAT_MAX : len;
                    fsm_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= CLEAR;
                end
                CLEAR: begin
                    fsm_reset_q <= 1'b0;
                    det_q       <= '0;
                    mismatch_q  <= 1'b0;
                    first_err_q <= '0;
                    i_q         <= '0;
                    if (eff_len_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        w_q     <= pat_q[0];
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    fsm_step_q <= 1'b1;
                    state_q    <= STEP;
                end
                STEP: begin
                    fsm_step_q <= 1'b0;
                    state_q    <= CHECK;
                end
                CHECK: begin
                    if (z_a && det_q != '1) det_q <= det_q + 1'b1;
                    if (set_mm) begin
                        mismatch_q  <= 1'b1;
                        first_err_q <= i_q;
                    end
                    if (fin) begin
                        w_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q + 1'b1;
                        pat_q   <= pat_q >> 1;
                        w_q     <= pat_q[1];
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign w         = w_q;
    assign fsm_reset = fsm_reset_q;
    assign fsm_step  = fsm_step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign det_count = det_q;
    assign mismatch  = mismatch_q;
    assign first_err = first_err_q;
endmodule

// File: doc/fsm_pattern_sequencer.md
Name: fsm_pattern_sequencer

Overview:
- Controller that drives a pair of sequence-detector FSMs, one one-hot and one binary encoded, from a stored stimulus pattern.
- Both FSMs share a `w` input; each returns its own `z`. The block applies the pattern one bit at a time, pulses a step enable, and compares the two `z` outputs in lockstep.
- It reports the detection count, a sticky mismatch flag and the index of the first disagreement.
- It sits between the board inputs and the two FSM instances, replacing manual switch/button stepping.

Parameters:
- PAT_W, 16, pattern storage width (max bits per run).
- CNT_W, 5, width of length/index/count fields; must satisfy 2^CNT_W > PAT_W.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- pattern  input  PAT_W  stimulus bits, bit 0 applied first; latched on start.
- len  input  CNT_W  number of bits to apply; latched on start.
- z_a  input  1  z from one-hot FSM.
- z_b  input  1  z from binary FSM.
- w  output  1  shared control input driven to both FSMs.
- fsm_reset  output  1  one-cycle reset pulse to both FSMs.
- fsm_step  output  1  one-cycle clock-enable pulse to both FSMs.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- det_count  output  CNT_W  number of CHECK cycles with z_a=1.
- mismatch  output  1  sticky flag, set when z_a != z_b in any CHECK.
- first_err  output  CNT_W  bit index of first mismatch (valid when mismatch=1).

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: w, fsm_reset, fsm_step, busy, done, det_count, mismatch, first_err.
  - Reset mid-run aborts immediately; no done pulse is issued.
- States: IDLE, CLEAR, DRIVE, STEP, CHECK, DONE. Bit index i is CNT_W wide.
- IDLE:
  - On start=1, latch pattern and eff_len = min(len, PAT_W), then go to CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - fsm_reset=1, busy=1.
  - Clear det_count, mismatch, first_err and i.
  - If eff_len=0, go to DONE; otherwise go to DRIVE.
- DRIVE (1 cycle, setup):
  - w=pattern_q[i], fsm_step=0, busy=1. Go to STEP.
- STEP (1 cycle):
  - w held, fsm_step=1, busy=1. Go to CHECK.
- CHECK (1 cycle):
  - w held, busy=1. The FSMs are Moore; z_a and z_b reflect the step taken at the end of STEP.
  - If z_a=1: det_count++, saturating at 2^CNT_W-1.
  - If z_a!=z_b and mismatch=0: set mismatch and set first_err=i.
  - If i=eff_len-1, go to DONE; otherwise i++ and go to DRIVE.
- DONE (1 cycle):
  - done=1, busy=0, w=0. Go to IDLE.
  - Results hold until the next CLEAR.
- Latency: start accepted at edge k → CLEAR in cycle k+1 → 3 cycles per bit → done asserted in cycle k+2+3·eff_len.
- fsm_reset and fsm_step are never high in the same cycle. fsm_step is high for exactly eff_len cycles per run.
- w changes only on entry to DRIVE or DONE, so it is stable for the whole STEP cycle.
- start held high through DONE starts a new run on the cycle after DONE (back in IDLE).

Optional Feature:
- Macro: HALT_ON_MISMATCH_EN.
- Defined: a CHECK that sets mismatch goes directly to DONE. No further steps are issued, and det_count includes that bit.
- Undefined: the run always completes all eff_len bits; mismatch only flags and records first_err.

Test Plan:
- Nominal run:
  - Stimulus: reset; pattern=16'h001C (w sequence 0,0,1,1,1), len=5, start pulse; z_a=z_b fed by a reference model (z=1 when last two w are equal).
  - Required: det_count=3, mismatch=0, done exactly 17 cycles after the start edge, fsm_step high 5 times, fsm_reset high once.
- Fault injection:
  - Stimulus: same as nominal, with z_b inverted during bit index 2 only.
  - Required: mismatch=1, first_err=2, det_count=3, run completes (macro off). With HALT_ON_MISMATCH_EN, done follows the bit-2 CHECK and fsm_step has pulsed 3 times.
- Boundary lengths:
  - Stimulus: len=0, start.
  - Required: CLEAR → DONE, done 2 cycles after start, no fsm_step, counts 0.
  - Stimulus: len=20, pattern=16'hFFFF.
  - Required: 16 steps, det_count=15.
- Reset mid-run:
  - Stimulus: assert reset during the STEP of bit 3.
  - Required: next cycle all outputs 0, state IDLE, no done; a fresh run then matches the nominal results.
- Start while busy:
  - Stimulus: pulse start during DRIVE with a different pattern.
  - Required: ignored; results match the original pattern; start held high through DONE begins the second run the cycle after DONE.
